// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single physical-memory port between the I-cache (fetch) and the
//   D-cache (MEM stage). One line transfer is in flight at a time; the winning
//   request's command, address and write line are latched so pmem sees stable
//   values for the whole transfer, and pmem_resp/pmem_rdata are routed back to
//   the granted cache only.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> a tie in IDLE goes to the side that did not
//                                    win last (first tie after reset goes to D)
//                       undefined -> fixed priority, D-cache always wins a tie
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_read, i_address             I-cache line read request / line address
//   i_rdata, i_resp               line returned to I-cache / completion pulse
//   d_read, d_write, d_address    D-cache read / writeback request, address
//   d_wdata                       D-cache writeback line
//   d_rdata, d_resp               line returned to D-cache / completion pulse
//   pmem_read, pmem_write         latched physical-memory command
//   pmem_address, pmem_wdata      latched physical-memory address / write line
//   pmem_rdata, pmem_resp         physical-memory read line / done pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t              state_r,        state_s;
    logic                last_grant_r,   last_grant_s;
    logic                pmem_read_r,    pmem_read_s;
    logic                pmem_write_r,   pmem_write_s;
    logic [ADDR_W-1:0]   pmem_address_r, pmem_address_s;
    logic [LINE_W-1:0]   pmem_wdata_r,   pmem_wdata_s;
    logic                d_req_s;
    logic                grant_d_s;

    // Winner selection for a request presented in IDLE
    always_comb begin
        d_req_s = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req_s && i_read) begin
            // last_grant resets to I, so the first tie after reset goes to D
            grant_d_s = (last_grant_r == GRANT_I);
        end else begin
            grant_d_s = d_req_s;
        end
`else
        grant_d_s = d_req_s;
`endif
    end

    // Next-state and latched pmem command computation
    always_comb begin
        state_s        = state_r;
        last_grant_s   = last_grant_r;
        pmem_read_s    = pmem_read_r;
        pmem_write_s   = pmem_write_r;
        pmem_address_s = pmem_address_r;
        pmem_wdata_s   = pmem_wdata_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    // A simultaneous read and write is a protocol error; write wins
                    state_s        = SERVE_D;
                    pmem_write_s   = d_write;
                    pmem_read_s    = ~d_write;
                    pmem_address_s = d_address;
                    pmem_wdata_s   = d_wdata;
                end else if (i_read) begin
                    state_s        = SERVE_I;
                    pmem_write_s   = 1'b0;
                    pmem_read_s    = 1'b1;
                    pmem_address_s = i_address;
                    pmem_wdata_s   = {LINE_W{1'b0}};
                end else begin
                    pmem_read_s    = 1'b0;
                    pmem_write_s   = 1'b0;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_s      = IDLE;
                    pmem_read_s  = 1'b0;
                    pmem_write_s = 1'b0;
                    last_grant_s = GRANT_I;
                end else begin
                    state_s      = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_s      = IDLE;
                    pmem_read_s  = 1'b0;
                    pmem_write_s = 1'b0;
                    last_grant_s = GRANT_D;
                end else begin
                    state_s      = SERVE_D;
                end
            end
            default: begin
                state_s      = IDLE;
                pmem_read_s  = 1'b0;
                pmem_write_s = 1'b0;
            end
        endcase
    end

    // State and latched pmem command registers; reset drops any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            last_grant_r   <= GRANT_I;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= {ADDR_W{1'b0}};
            pmem_wdata_r   <= {LINE_W{1'b0}};
        end else begin
            state_r        <= state_s;
            last_grant_r   <= last_grant_s;
            pmem_read_r    <= pmem_read_s;
            pmem_write_r   <= pmem_write_s;
            pmem_address_r <= pmem_address_s;
            pmem_wdata_r   <= pmem_wdata_s;
        end
    end

    // Route the memory response to the granted cache only; zero otherwise
    always_comb begin
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = {LINE_W{1'b0}};
        d_rdata = {LINE_W{1'b0}};
        if (pmem_resp && (state_r == SERVE_I)) begin
            i_resp  = 1'b1;
            i_rdata = pmem_rdata;
        end else if (pmem_resp && (state_r == SERVE_D)) begin
            d_resp  = 1'b1;
            d_rdata = pmem_rdata;
        end else begin
            i_resp  = 1'b0;
            d_resp  = 1'b0;
        end
    end

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = pmem_address_r;
    assign pmem_wdata   = pmem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A table of request vectors is applied;
//   for each one the expected grant sequence is pushed to a scoreboard queue and
//   popped as the arbiter issues pmem commands. The bench plays the memory,
//   returning pmem_resp after a per-vector delay. Hand-written sequences cover
//   both-held arbitration, stretched pmem_resp and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write;
    logic [15:0]   i_address, d_address;
    logic [127:0]  d_wdata;
    logic [127:0]  i_rdata, d_rdata;
    logic          i_resp, d_resp;
    logic          pmem_read, pmem_write;
    logic [15:0]   pmem_address;
    logic [127:0]  pmem_wdata;
    logic [127:0]  pmem_rdata;
    logic          pmem_resp;

    int checks = 0;
    int errors = 0;
    logic lg = 1'b0;   // bench's own record of the last granted side (1 = D)

    typedef struct {
        logic          side;   // 1 = D, 0 = I
        logic          wr;
        logic [15:0]   addr;
        logic [127:0]  wd;
        int            delay;
    } xfer_t;

    typedef struct {
        logic          i_rd;
        logic          d_rd;
        logic          d_wr;
        logic [15:0]   i_addr;
        logic [15:0]   d_addr;
        logic [127:0]  d_wd;
        int            delay;
        logic          scramble;
        logic          exp_d_first;
    } vec_t;

    xfer_t q[$];
    vec_t  vt[7];

    localparam logic [127:0] IDLE_RDATA = {4{32'hDEADBEEF}};

    mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        return {8{a ^ 16'hBEEF}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic side, input vec_t v);
        xfer_t e;
        e.side  = side;
        e.wr    = side ? v.d_wr : 1'b0;
        e.addr  = side ? v.d_addr : v.i_addr;
        e.wd    = side ? v.d_wd : 128'h0;
        e.delay = v.delay;
        return e;
    endfunction

    // Wait for the grant, check the latched command, act as memory, check the response
    task automatic do_xfer(input xfer_t e, input logic scramble, input logic drop,
                           input logic stretch);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pmem_read | pmem_write) && n < 20);
        chk("grant_latency", 128'(n), 128'(1));
        chk("pmem_write",   128'(pmem_write), 128'(e.wr));
        chk("pmem_read",    128'(pmem_read), 128'(!e.wr));
        chk("pmem_address", 128'(pmem_address), 128'(e.addr));
        chk("pmem_wdata",   pmem_wdata, e.wd);
        if (scramble) begin
            if (e.side) begin
                d_address = 16'h2000;
                d_wdata   = ~d_wdata;
            end else begin
                i_address = 16'h2000;
            end
        end
        for (int k = 1; k < e.delay; k++) begin
            @(negedge clk);
            chk("hold_address", 128'(pmem_address), 128'(e.addr));
            chk("hold_wdata",   pmem_wdata, e.wd);
            chk("hold_cmd",     128'({pmem_read, pmem_write}), 128'({!e.wr, e.wr}));
            chk("hold_resp",    128'({i_resp, d_resp}), 128'(2'b00));
            chk("hold_rdata",   i_rdata | d_rdata, 128'h0);
        end
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line(e.addr);
        #1;
        chk("i_resp",  128'(i_resp), 128'(!e.side));
        chk("d_resp",  128'(d_resp), 128'(e.side));
        chk("i_rdata", i_rdata, e.side ? 128'h0 : mem_line(e.addr));
        chk("d_rdata", d_rdata, e.side ? mem_line(e.addr) : 128'h0);
        lg = e.side;
        @(negedge clk);
        if (drop) begin
            if (e.side) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read  = 1'b0;
            end
        end
        if (!stretch) pmem_resp = 1'b0;
        pmem_rdata = IDLE_RDATA;
        #1;
        chk("idle_cmd",  128'({pmem_read, pmem_write}), 128'(2'b00));
        chk("idle_resp", 128'({i_resp, d_resp}), 128'(2'b00));
        if (stretch) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            #1;
            chk("stretch_cmd",  128'({pmem_read, pmem_write}), 128'(2'b00));
            chk("stretch_resp", 128'({i_resp, d_resp}), 128'(2'b00));
        end
    endtask

    initial begin
        xfer_t e;
        logic  g, first_d, tie;

        vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 128'h0, 5, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1230, {16{8'hA5}}, 3, 1'b1, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0080, {8{16'h1111}}, 1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, {8{16'h2222}}, 2, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b1, 16'h0110, 16'h0210, {8{16'h3333}}, 4, 1'b0, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0220, {8{16'h4444}}, 2, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b0, 1'b0, 16'h0120, 16'h0000, 128'h0, 1, 1'b0, 1'b0};

        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = 16'h0; d_address = 16'h0; d_wdata = 128'h0;
        pmem_rdata = IDLE_RDATA; pmem_resp = 1'b0;
        #1;
        chk("rst_cmd",     128'({pmem_read, pmem_write}), 128'(2'b00));
        chk("rst_address", 128'(pmem_address), 128'(16'h0));
        chk("rst_wdata",   pmem_wdata, 128'h0);
        chk("rst_resp",    128'({i_resp, d_resp}), 128'(2'b00));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lg  = 1'b0;

        // Both caches hold read requests across four transfers
        i_read = 1'b1; i_address = 16'h0300;
        d_read = 1'b1; d_address = 16'h0400; d_wdata = {8{16'h5555}};
        g = lg;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            e.side = (g == 1'b0);
`else
            e.side = 1'b1;
`endif
            g       = e.side;
            e.wr    = 1'b0;
            e.addr  = e.side ? 16'h0400 : 16'h0300;
            e.wd    = e.side ? {8{16'h5555}} : 128'h0;
            e.delay = 2;
            q.push_back(e);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            do_xfer(e, 1'b0, 1'b0, 1'b0);
        end
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int v = 0; v < 7; v++) begin
            i_read = vt[v].i_rd; d_read = vt[v].d_rd; d_write = vt[v].d_wr;
            i_address = vt[v].i_addr; d_address = vt[v].d_addr; d_wdata = vt[v].d_wd;
            tie     = vt[v].i_rd & (vt[v].d_rd | vt[v].d_wr);
            first_d = vt[v].exp_d_first;
`ifdef ARB_ROUND_ROBIN_EN
            if (tie) first_d = (lg == 1'b0);
`endif
            q.push_back(mk(first_d, vt[v]));
            if (tie) q.push_back(mk(!first_d, vt[v]));
            while (q.size() > 0) begin
                e = q.pop_front();
                do_xfer(e, vt[v].scramble, 1'b1, 1'b0);
            end
        end

        // pmem_resp held for two cycles: only the first counts
        i_read = 1'b1; i_address = 16'h0500;
        e.side = 1'b0; e.wr = 1'b0; e.addr = 16'h0500; e.wd = 128'h0; e.delay = 2;
        q.push_back(e);
        e = q.pop_front();
        do_xfer(e, 1'b0, 1'b1, 1'b1);

        // Reset two cycles into an I transfer
        i_read = 1'b1; i_address = 16'h0600;
        repeat (2) @(negedge clk);
        chk("pre_rst_read", 128'(pmem_read), 128'(1'b1));
        chk("pre_rst_addr", 128'(pmem_address), 128'(16'h0600));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_read", 128'(pmem_read), 128'(1'b0));
        chk("async_rst_addr", 128'(pmem_address), 128'(16'h0));
        i_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lg  = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line(16'h0600);
        #1;
        chk("late_resp_i",     128'({i_resp, d_resp}), 128'(2'b00));
        chk("late_resp_rdata", i_rdata | d_rdata, 128'h0);
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = IDLE_RDATA;
        #1;
        chk("late_resp_cmd", 128'({pmem_read, pmem_write}), 128'(2'b00));

        // First tie after reset goes to D in either mode
        i_read = 1'b1; i_address = 16'h0700;
        d_read = 1'b1; d_address = 16'h0800; d_wdata = {8{16'h6666}};
        e.side = 1'b1; e.wr = 1'b0; e.addr = 16'h0800; e.wd = {8{16'h6666}}; e.delay = 3;
        q.push_back(e);
        e.side = 1'b0; e.addr = 16'h0700; e.wd = 128'h0;
        q.push_back(e);
        while (q.size() > 0) begin
            e = q.pop_front();
            do_xfer(e, 1'b0, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
